// File: rtl/led_pattern_gen_if.sv
// Switch/LED bundle of the LED pattern generator: run/mode/dir controls in,
// LED pattern and step pulse out.
interface led_pattern_gen_if #(
    parameter int WIDTH = 4
) ();
    logic             sw;
    logic [1:0]       mode;
    logic             dir;
    logic [WIDTH-1:0] data;
    logic             step;

    modport master (output sw, mode, dir, input data, step);
    modport slave  (input sw, mode, dir, output data, step);
endinterface

// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator: prescaled stepping through rotate, bounce,
// up/down count and thermometer-fill patterns, plus a registered step pulse.
module led_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic              clk,
    input  logic              res,
    led_pattern_gen_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        M_SHIFT  = 2'b00,
        M_BOUNCE = 2'b01,
        M_COUNT  = 2'b10,
        M_FILL   = 2'b11
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] data_q, data_d, nxt;
    logic             bdir_q, bdir_d, bdir_nxt;
    logic             step_q, step_d;

    // Pattern successor for the current mode; only used on a step edge.
    always_comb begin
        nxt      = data_q;
        bdir_nxt = bdir_q;
        unique case (mode_q)
            M_SHIFT: nxt = bus.dir ? {data_q[0], data_q[WIDTH-1:1]}
                                   : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            M_BOUNCE: begin
                if (!bdir_q && data_q[WIDTH-1]) begin
                    nxt      = data_q >> 1;
                    bdir_nxt = 1'b1;
                end else if (bdir_q && data_q[0]) begin
                    nxt      = data_q << 1;
                    bdir_nxt = 1'b0;
                end else begin
                    nxt = bdir_q ? (data_q >> 1) : (data_q << 1);
                end
            end
            M_COUNT: nxt = bus.dir ? data_q - WIDTH'(1) : data_q + WIDTH'(1);
            M_FILL:  nxt = (&data_q) ? '0 : {data_q[WIDTH-2:0], 1'b1};
            default: nxt = data_q;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        pre_d  = pre_q;
        data_d = data_q;
        bdir_d = bdir_q;
        step_d = 1'b0;
        if (bus.mode != mode_q) begin
            // A mode change reloads even if it collides with a due step.
            mode_d = mode_e'(bus.mode);
            pre_d  = '0;
            bdir_d = 1'b0;
            data_d = (bus.mode == M_SHIFT || bus.mode == M_BOUNCE) ? WIDTH'(1) : '0;
        end else if (bus.sw) begin
            if (pre_q == PW'(DIV - 1)) begin
                pre_d  = '0;
                data_d = nxt;
                bdir_d = bdir_nxt;
                step_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            mode_q <= M_SHIFT;
            pre_q  <= '0;
            data_q <= WIDTH'(1);
            bdir_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            data_q <= data_d;
            bdir_q <= bdir_d;
            step_q <= step_d;
        end
    end

    assign bus.data = data_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: two generator instances (4-bit/DIV 4 and 8-bit/DIV 1) share
// stimulus; a position-index reference model predicts every cycle's outputs.
module tb_led_pattern_gen;
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    led_pattern_gen_if #(.WIDTH(4)) if4 ();
    led_pattern_gen_if #(.WIDTH(8)) if8 ();

    led_pattern_gen #(.WIDTH(4), .DIV(4)) dut4 (.clk(clk), .res(res), .bus(if4.slave));
    led_pattern_gen #(.WIDTH(8), .DIV(1)) dut8 (.clk(clk), .res(res), .bus(if8.slave));

    // Model state: the pattern is a position index into each mode's sequence.
    typedef struct {
        int mode;
        int idx;
        int cnt;
        bit stp;
    } mdl_t;

    typedef struct {
        longint data;
        bit     step;
    } exp_t;

    mdl_t m4, m8;
    exp_t q4[$], q8[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    function automatic longint pat(mdl_t m, int w);
        case (m.mode)
            0: return longint'(1) << m.idx;
            1: return longint'(1) << ((m.idx < w) ? m.idx : (2*w - 2 - m.idx));
            2: return longint'(m.idx);
            default: return (longint'(1) << m.idx) - 1;
        endcase
    endfunction

    function automatic int adv(mdl_t m, int w, bit d);
        case (m.mode)
            0: return (m.idx + (d ? w - 1 : 1)) % w;
            1: return (m.idx + 1) % (2*w - 2);
            2: return (m.idx + (d ? (1 << w) - 1 : 1)) % (1 << w);
            default: return (m.idx + 1) % (w + 1);
        endcase
    endfunction

    function automatic mdl_t mstep(mdl_t m, int w, int div, bit r, bit s, int md, bit d);
        mdl_t n = m;
        n.stp = 1'b0;
        if (r) begin
            n.mode = 0; n.idx = 0; n.cnt = 0;
        end else if (md != m.mode) begin
            n.mode = md; n.idx = 0; n.cnt = 0;
        end else if (s) begin
            if (m.cnt == div - 1) begin
                n.cnt = 0;
                n.idx = adv(m, w, d);
                n.stp = 1'b1;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end
        return n;
    endfunction

    task automatic drive(bit r, bit s, logic [1:0] md, bit d);
        exp_t e;
        res = r;
        if4.sw = s; if4.mode = md; if4.dir = d;
        if8.sw = s; if8.mode = md; if8.dir = d;
        m4 = mstep(m4, 4, 4, r, s, int'(md), d);
        m8 = mstep(m8, 8, 1, r, s, int'(md), d);
        e.data = pat(m4, 4); e.step = m4.stp; q4.push_back(e);
        e.data = pat(m8, 8); e.step = m8.stp; q8.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are valid every cycle, compared just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q4.size() != 0) begin
                e = q4.pop_front();
                checks += 2;
                if (longint'(if4.data) != e.data) begin
                    failures++;
                    $display("FAIL w4.data cyc=%0d got=%h exp=%h", cyc, if4.data, e.data[3:0]);
                end
                if (if4.step !== e.step) begin
                    failures++;
                    $display("FAIL w4.step cyc=%0d got=%b exp=%b", cyc, if4.step, e.step);
                end
            end
            if (q8.size() != 0) begin
                e = q8.pop_front();
                checks += 2;
                if (longint'(if8.data) != e.data) begin
                    failures++;
                    $display("FAIL w8.data cyc=%0d got=%h exp=%h", cyc, if8.data, e.data[7:0]);
                end
                if (if8.step !== e.step) begin
                    failures++;
                    $display("FAIL w8.step cyc=%0d got=%b exp=%b", cyc, if8.step, e.step);
                end
            end
        end
    end

    initial begin
        logic [1:0] md;
        bit d;
        m4 = '{0, 0, 0, 1'b0};
        m8 = '{0, 0, 0, 1'b0};
        // Reset, then idle hold
        repeat (3)  drive(1, 0, 2'b00, 0);
        repeat (20) drive(0, 0, 2'b00, 0);
        // SHIFT left then right
        repeat (16) drive(0, 1, 2'b00, 0);
        repeat (8)  drive(0, 1, 2'b00, 1);
        // BOUNCE with dir toggling
        for (int k = 0; k < 29; k++) drive(0, 1, 2'b01, k[2]);
        // COUNT down then up
        repeat (9)  drive(0, 1, 2'b10, 1);
        repeat (8)  drive(0, 1, 2'b10, 0);
        // FILL
        repeat (25) drive(0, 1, 2'b11, 0);
        // Pause/resume
        drive(0, 0, 2'b00, 0);
        repeat (2)  drive(0, 1, 2'b00, 0);
        repeat (10) drive(0, 0, 2'b00, 0);
        repeat (4)  drive(0, 1, 2'b00, 0);
        // Mode change colliding with a due step
        for (int k = 0; k < 8 && m4.cnt != 3; k++) drive(0, 1, 2'b00, 0);
        drive(0, 1, 2'b11, 0);
        repeat (3) drive(0, 1, 2'b11, 0);
        // Reset in the middle of BOUNCE at 0100, mode held at BOUNCE
        drive(0, 1, 2'b01, 0);
        for (int k = 0; k < 40 && pat(m4, 4) != 64'd4; k++) drive(0, 1, 2'b01, 0);
        drive(1, 1, 2'b01, 1);
        repeat (28) drive(0, 1, 2'b01, 0);
        // Random phase
        md = 2'b00;
        d  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) d = ~d;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, md, d);
        end
        @(posedge clk);
        #2;
        checks++;
        if (q4.size() + q8.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q4.size() + q8.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
